// File: rtl/mem_wb_stage_if.sv
// Memory bus between mem_wb_stage (master) and a memory responder (slave).
//   mem_req   master->slave  transfer request, held high for the whole transfer
//   mem_we    master->slave  1 = store, 0 = load
//   mem_addr  master->slave  transfer address
//   mem_wdata master->slave  store data
//   mem_rdata slave->master  load data, valid with mem_ack
//   mem_ack   slave->master  transfer complete, sampled on posedge
interface mem_wb_stage_if;
    localparam int unsigned DW = 32;

    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_wb_stage.sv
// CPU32 back end: runs up to two memory transfers for an executed instruction,
// then writes the register file and updates the status register.
// Ports:
//   clk, rst              clock, async active-high reset
//   in_valid / in_ready   handshake for execute results (ready while idle)
//   r1, r2, cres, n..v,cc execute results, condition result, flags, status enable
//   m_a1/2, m_r1/2_op     per-slot memory address and op (1 = LD, 2 = ST)
//   r_a1/2, r_op          per-slot register write address and enables
//   bus                   memory bus master
//   rf_we/wa/wd 1/2       register file write ports, active only in WB
//   st                    status register {28'b0,n,z,c,v}
//   bus_err               sticky transfer-timeout flag
module mem_wb_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] r1,
    input  logic [31:0] r2,
    input  logic        cres,
    input  logic        n,
    input  logic        z,
    input  logic        c,
    input  logic        v,
    input  logic        cc,
    input  logic [31:0] m_a1,
    input  logic [31:0] m_a2,
    input  logic [3:0]  m_r1_op,
    input  logic [3:0]  m_r2_op,
    input  logic [4:0]  r_a1,
    input  logic [4:0]  r_a2,
    input  logic [3:0]  r_op,
    mem_wb_stage_if.master bus,
    output logic        rf_we1,
    output logic        rf_we2,
    output logic [4:0]  rf_wa1,
    output logic [4:0]  rf_wa2,
    output logic [31:0] rf_wd1,
    output logic [31:0] rf_wd2,
    output logic [31:0] st,
    output logic        bus_err
);
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [3:0]  OP_LD = 4'h1;
    localparam logic [3:0]  OP_ST = 4'h2;

    typedef enum logic [1:0] {IDLE, MEM1, MEM2, WB} state_t;

    state_t           state;
    logic [31:0]      l_r1, l_r2, l_a1, l_a2;
    logic [3:0]       l_op1, l_op2, l_nzcv;
    logic [4:0]       l_ra1, l_ra2;
    logic [1:0]       l_rop;
    logic             l_cres, l_cc;
    logic             err1, err2;
    logic [CNT_W-1:0] cnt;
    logic             timeout_c;
    logic             we1_c;
    logic             unused_rop_hi;

    assign unused_rop_hi = ^r_op[3:2];

    function automatic logic is_mem(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

    // Last allowed wait cycle of the current transfer; TIMEOUT==0 never expires.
    assign timeout_c = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    // Control FSM, operand latches, status register and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            l_r1    <= '0;
            l_r2    <= '0;
            l_a1    <= '0;
            l_a2    <= '0;
            l_op1   <= '0;
            l_op2   <= '0;
            l_nzcv  <= '0;
            l_ra1   <= '0;
            l_ra2   <= '0;
            l_rop   <= '0;
            l_cres  <= 1'b0;
            l_cc    <= 1'b0;
            err1    <= 1'b0;
            err2    <= 1'b0;
            cnt     <= '0;
            st      <= '0;
            bus_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        l_r1   <= r1;
                        l_r2   <= r2;
                        l_a1   <= m_a1;
                        l_a2   <= m_a2;
                        l_op1  <= m_r1_op;
                        l_op2  <= m_r2_op;
                        l_nzcv <= {n, z, c, v};
                        l_ra1  <= r_a1;
                        l_ra2  <= r_a2;
                        l_rop  <= r_op[1:0];
                        l_cres <= cres;
                        l_cc   <= cc;
                        err1   <= 1'b0;
                        err2   <= 1'b0;
                        cnt    <= '0;
                        if (!cres)                state <= WB;
                        else if (is_mem(m_r1_op)) state <= MEM1;
                        else if (is_mem(m_r2_op)) state <= MEM2;
                        else                      state <= WB;
                    end
                end
                MEM1: begin
                    // ack wins over a simultaneous timeout
                    if (bus.mem_ack || timeout_c) begin
                        if (bus.mem_ack) begin
                            if (l_op1 == OP_LD) l_r1 <= bus.mem_rdata;
                        end else begin
                            err1    <= 1'b1;
                            bus_err <= 1'b1;
                        end
                        cnt   <= '0;
                        state <= is_mem(l_op2) ? MEM2 : WB;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                MEM2: begin
                    if (bus.mem_ack || timeout_c) begin
                        if (bus.mem_ack) begin
                            if (l_op2 == OP_LD) l_r2 <= bus.mem_rdata;
                        end else begin
                            err2    <= 1'b1;
                            bus_err <= 1'b1;
                        end
                        cnt   <= '0;
                        state <= WB;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WB: begin
                    if (l_cc && l_cres) st <= {28'b0, l_nzcv};
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus and register-file outputs decoded purely from state and latches.
    always_comb begin
        in_ready      = (state == IDLE);
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        we1_c         = 1'b0;
        rf_we1        = 1'b0;
        rf_we2        = 1'b0;
        rf_wa1        = '0;
        rf_wa2        = '0;
        rf_wd1        = '0;
        rf_wd2        = '0;
        case (state)
            MEM1: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = (l_op1 == OP_ST);
                bus.mem_addr  = l_a1;
                bus.mem_wdata = l_r1;
            end
            MEM2: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = (l_op2 == OP_ST);
                bus.mem_addr  = l_a2;
                bus.mem_wdata = l_r2;
            end
            WB: begin
                we1_c  = l_rop[0] && l_cres && !err1;
                rf_we1 = we1_c;
                // Slot 1 wins a same-register collision.
                rf_we2 = l_rop[1] && l_cres && !err2 && !(we1_c && (l_ra1 == l_ra2));
                rf_wa1 = l_ra1;
                rf_wa2 = l_ra2;
                rf_wd1 = l_r1;
                rf_wd2 = l_r2;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a small memory responder.
module tb_mem_wb_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] r1, r2, m_a1, m_a2;
    logic        cres, n, z, c, v, cc;
    logic [3:0]  m_r1_op, m_r2_op, r_op;
    logic [4:0]  r_a1, r_a2;
    logic        rf_we1, rf_we2, bus_err;
    logic [4:0]  rf_wa1, rf_wa2;
    logic [31:0] rf_wd1, rf_wd2, st;

    int          n_cmp = 0;
    int          n_err = 0;

    // Responder controls and transfer log
    int          ack_wait = 0;
    logic        ack_en = 1'b1;
    logic [31:0] rdata_val = '0;
    int          wcnt = 0;
    int          xfer_n = 0;
    logic [31:0] xfer_addr [8];
    logic        xfer_we   [8];

    mem_wb_stage_if mbus();

    mem_wb_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .r1(r1), .r2(r2), .cres(cres), .n(n), .z(z), .c(c), .v(v), .cc(cc),
        .m_a1(m_a1), .m_a2(m_a2), .m_r1_op(m_r1_op), .m_r2_op(m_r2_op),
        .r_a1(r_a1), .r_a2(r_a2), .r_op(r_op), .bus(mbus),
        .rf_we1(rf_we1), .rf_we2(rf_we2), .rf_wa1(rf_wa1), .rf_wa2(rf_wa2),
        .rf_wd1(rf_wd1), .rf_wd2(rf_wd2), .st(st), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Memory responder: acks after ack_wait idle cycles of mem_req.
    initial begin
        mbus.mem_ack   = 1'b0;
        mbus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mbus.mem_req && !rst) begin
                if (mbus.mem_ack) wcnt = 0;
                if (ack_en && wcnt == ack_wait) begin
                    mbus.mem_ack   = 1'b1;
                    mbus.mem_rdata = rdata_val;
                    if (xfer_n < 8) begin
                        xfer_addr[xfer_n] = mbus.mem_addr;
                        xfer_we[xfer_n]   = mbus.mem_we;
                    end
                    xfer_n++;
                end else begin
                    mbus.mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                mbus.mem_ack = 1'b0;
                wcnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 30 && !in_ready; i++) step();
        chk(tag, 32'(in_ready), 32'd1);
    endtask

    // Present one instruction; returns at the first negedge after the accept edge.
    task automatic go();
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        step();
    endtask

    task automatic clr();
        r1 = '0; r2 = '0; m_a1 = '0; m_a2 = '0;
        cres = 1'b1; {n, z, c, v} = 4'b0000; cc = 1'b0;
        m_r1_op = '0; m_r2_op = '0; r_op = '0; r_a1 = '0; r_a2 = '0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        clr();
        repeat (2) step();
        chk("rst_req",   32'(mbus.mem_req), 32'd0);
        chk("rst_addr",  mbus.mem_addr, 32'd0);
        chk("rst_st",    st, 32'd0);
        chk("rst_err",   32'(bus_err), 32'd0);
        chk("rst_we1",   32'(rf_we1), 32'd0);
        rst = 1'b0;
        step();
        chk("rst_ready", 32'(in_ready), 32'd1);

        // ALU only
        r1 = 32'h5; r_a1 = 5'd3; r_op = 4'h1; cc = 1'b1; {n, z, c, v} = 4'b0100;
        go();
        chk("alu_we1",   32'(rf_we1), 32'd1);
        chk("alu_wa1",   32'(rf_wa1), 32'd3);
        chk("alu_wd1",   rf_wd1, 32'h5);
        chk("alu_we2",   32'(rf_we2), 32'd0);
        chk("alu_busy",  32'(in_ready), 32'd0);
        chk("alu_st_pre", st, 32'd0);
        step();
        chk("alu_st",    st, 32'h4);
        chk("alu_ready", 32'(in_ready), 32'd1);
        chk("alu_we1_off", 32'(rf_we1), 32'd0);

        // Squash
        clr();
        cres = 1'b0; m_r1_op = 4'h2; m_a1 = 32'h40; r_op = 4'h3; cc = 1'b1;
        {n, z, c, v} = 4'b1111; r_a1 = 5'd1; r_a2 = 5'd2;
        go();
        chk("sq_req",  32'(mbus.mem_req), 32'd0);
        chk("sq_we1",  32'(rf_we1), 32'd0);
        chk("sq_we2",  32'(rf_we2), 32'd0);
        step();
        chk("sq_st",   st, 32'h4);
        chk("sq_xfer", 32'(xfer_n), 32'd0);
        wait_ready("sq_ready");

        // LD then ST, two wait cycles each
        clr();
        ack_wait = 2; rdata_val = 32'hDEAD;
        m_r1_op = 4'h1; m_a1 = 32'h100; r1 = 32'h11;
        m_r2_op = 4'h2; m_a2 = 32'h104; r2 = 32'h77;
        r_a1 = 5'd1; r_a2 = 5'd2; r_op = 4'h3;
        go();
        chk("ls_req1",  32'(mbus.mem_req), 32'd1);
        chk("ls_we1",   32'(mbus.mem_we), 32'd0);
        chk("ls_addr1", mbus.mem_addr, 32'h100);
        repeat (3) step();
        chk("ls_req2",  32'(mbus.mem_req), 32'd1);
        chk("ls_we2",   32'(mbus.mem_we), 32'd1);
        chk("ls_addr2", mbus.mem_addr, 32'h104);
        chk("ls_wdata2", mbus.mem_wdata, 32'h77);
        repeat (3) step();
        chk("ls_req_off", 32'(mbus.mem_req), 32'd0);
        chk("ls_rfwe1", 32'(rf_we1), 32'd1);
        chk("ls_wd1",   rf_wd1, 32'hDEAD);
        chk("ls_rfwe2", 32'(rf_we2), 32'd1);
        chk("ls_wa2",   32'(rf_wa2), 32'd2);
        chk("ls_wd2",   rf_wd2, 32'h77);
        chk("ls_xfer_n", 32'(xfer_n), 32'd2);
        chk("ls_log0",  xfer_addr[0], 32'h100);
        chk("ls_log1",  {xfer_addr[1][30:0], xfer_we[1]}, {31'h104, 1'b1});
        wait_ready("ls_ready");

        // Same destination register: slot 1 wins
        clr();
        r_a1 = 5'd7; r_a2 = 5'd7; r_op = 4'h3; r1 = 32'h1; r2 = 32'h2;
        go();
        chk("same_we1", 32'(rf_we1), 32'd1);
        chk("same_wd1", rf_wd1, 32'h1);
        chk("same_we2", 32'(rf_we2), 32'd0);
        wait_ready("same_ready");

        // Timeout on an LD with no ack
        clr();
        ack_en = 1'b0;
        m_r1_op = 4'h1; m_a1 = 32'h200; r1 = 32'h99; r_a1 = 5'd5; r_op = 4'h1;
        go();
        repeat (3) step();
        chk("to_req_last", 32'(mbus.mem_req), 32'd1);
        chk("to_err_pre",  32'(bus_err), 32'd0);
        step();
        chk("to_req_drop", 32'(mbus.mem_req), 32'd0);
        chk("to_err",      32'(bus_err), 32'd1);
        chk("to_we1",      32'(rf_we1), 32'd0);
        step();
        chk("to_ready",    32'(in_ready), 32'd1);

        // Slot-2-only load with immediate ack
        clr();
        ack_en = 1'b1; ack_wait = 0; rdata_val = 32'hBEEF;
        m_r2_op = 4'h1; m_a2 = 32'h300; r2 = 32'h3; r_a2 = 5'd9; r_op = 4'h2;
        go();
        chk("s2_req",  32'(mbus.mem_req), 32'd1);
        chk("s2_addr", mbus.mem_addr, 32'h300);
        step();
        chk("s2_we1",  32'(rf_we1), 32'd0);
        chk("s2_we2",  32'(rf_we2), 32'd1);
        chk("s2_wd2",  rf_wd2, 32'hBEEF);
        chk("s2_err_sticky", 32'(bus_err), 32'd1);
        wait_ready("s2_ready");

        // Reset in the middle of MEM1
        clr();
        ack_en = 1'b0;
        m_r1_op = 4'h1; m_a1 = 32'h400; r_op = 4'h1;
        go();
        step();
        chk("rm_req", 32'(mbus.mem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rm_req_drop", 32'(mbus.mem_req), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("rm_ready", 32'(in_ready), 32'd1);
        chk("rm_st",    st, 32'd0);
        chk("rm_err",   32'(bus_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
